// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: state encoding,
// datapath widths, boot vector and the sequential-PC helper.
package fetch_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_BOOT_ADDR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select for the PC register load: boot vector, then exception,
// then branch, then the sequential +4 after an accepted delivery.
module fetch_redirect_mux
  import fetch_ctrl_pkg::*;
(
  input  logic            boot,
  input  logic [XLEN-1:0] boot_addr,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_target,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            seq_en,
  input  logic [XLEN-1:0] pc,
  output logic            redirect,
  output logic            load,
  output logic [XLEN-1:0] next_pc
);

  // Redirects are meaningless in BOOT, so boot masks both redirect sources.
  always_comb begin
    redirect = 1'b0;
    load     = 1'b0;
    next_pc  = seq_pc(pc);
    if (boot) begin
      load    = 1'b1;
      next_pc = boot_addr;
    end else if (exc_valid) begin
      redirect = 1'b1;
      load     = 1'b1;
      next_pc  = exc_target;
    end else if (br_valid) begin
      redirect = 1'b1;
      load     = 1'b1;
      next_pc  = br_target;
    end else if (seq_en) begin
      load = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer, one bus transaction outstanding.
// Define FETCH_ALIGN_CHECK_EN to report misaligned PCs via out_adel.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_i,
  output logic              pc_en,
  output logic [XLEN-1:0]   next_pc,
  input  logic              exc_valid,
  input  logic [XLEN-1:0]   exc_target,
  input  logic              br_valid,
  input  logic [XLEN-1:0]   br_target,
  output logic              inst_req,
  output logic [XLEN-1:0]   inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_adel,
  output fetch_state_t      state
);

  logic discard;
  logic redirect;
  logic load;
  logic misaligned;
  logic req_accepted;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |pc_i[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Moore-style request: depends only on state and the PC register.
  assign inst_req     = (state == ST_REQ) && !misaligned;
  assign inst_addr    = pc_i;
  assign req_accepted = inst_req && inst_addr_ok;

  fetch_redirect_mux u_redirect_mux (
    .boot       (state == ST_BOOT),
    .boot_addr  (BOOT_ADDR),
    .exc_valid  (exc_valid),
    .exc_target (exc_target),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .seq_en     ((state == ST_HOLD) && out_ready),
    .pc         (pc_i),
    .redirect   (redirect),
    .load       (load),
    .next_pc    (next_pc)
  );

  // BOOT is the reset state, so the load is held off while rst is asserted.
  assign pc_en = load && !rst;

  // ID handshake: an instruction transfers on a cycle where out_valid and
  // out_ready are both high; out_pc/out_inst/out_adel hold while out_valid
  // is high and out_ready is low, and out_valid never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BOOT;
      discard   <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      out_adel  <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_REQ;

        ST_REQ: begin
          if (redirect) begin
            // An address already accepted now targets the old PC.
            if (req_accepted) begin
              state   <= ST_WAIT;
              discard <= 1'b1;
            end
`ifdef FETCH_ALIGN_CHECK_EN
          end else if (misaligned) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_adel  <= 1'b1;
            out_pc    <= pc_i;
            out_inst  <= '0;
`endif
          end else if (req_accepted) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (inst_data_ok) begin
            discard <= 1'b0;
            if (discard || redirect) begin
              state <= ST_REQ;
            end else begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              out_adel  <= 1'b0;
              out_pc    <= pc_i;
              out_inst  <= inst_rdata;
            end
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (redirect || out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_REQ;
          end
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model, a bus responder
// with configurable data latency and a handshake scoreboard.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pc_q;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_target = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;
  fetch_state_t state;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_q),
    .pc_en        (pc_en),
    .next_pc      (next_pc),
    .exc_valid    (exc_valid),
    .exc_target   (exc_target),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_adel     (out_adel),
    .state        (state)
  );

  // PC register owned outside the sequencer.
  always @(posedge clk) begin
    if (rst) pc_q <= 32'h0;
    else if (pc_en) pc_q <= next_pc;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int boot_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return {16'h2408, a[15:0] + 16'd1};
  endfunction

  // ---------------- bus responder ----------------
  int          lat = 0;
  bit          addr_block = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          prev_acc = 1'b0;
  bit          prev_data = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (prev_data) pend = 1'b0;
        if (prev_acc) begin
          pend = 1'b1;
          pend_addr = prev_addr;
          cnt = lat;
        end else if (pend && cnt != 0) begin
          cnt--;
        end
      end
      inst_data_ok = pend && (cnt == 0) && !rst;
      inst_rdata   = inst_data_ok ? mem_of(pend_addr) : 32'hDEAD_BEEF;
      inst_addr_ok = inst_req && !pend && !addr_block && !rst;
      #4;
      prev_acc  = inst_req && inst_addr_ok && !rst;
      prev_addr = inst_addr;
      prev_data = inst_data_ok && !rst;
    end
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int hs_count = 0;
  int hs_cyc[$];

  initial begin : monitor
    logic [64:0] act;
    logic [64:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready) begin
        act = {out_pc, out_inst, out_adel};
        hs_count++;
        hs_cyc.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL delivery: got pc=%h inst=%h adel=%b, expected no delivery",
                   out_pc, out_inst, out_adel);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL delivery: got pc=%h inst=%h adel=%b, expected pc=%h inst=%h adel=%b",
                     out_pc, out_inst, out_adel, exp[64:33], exp[32:1], exp[0]);
          end
        end
      end
    end
  end

  function automatic logic [64:0] pack_exp(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic adel);
    return {pc, inst, adel};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    exc_valid = 1'b0;
    br_valid = 1'b0;
    out_ready = 1'b0;
    addr_block = 1'b0;
    lat = 0;
    @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_state", 64'(state), 64'(ST_BOOT));
    check("rst_pc_en", 64'(pc_en), 64'd0);
    check("rst_inst_req", 64'(inst_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc_inst", {out_pc, out_inst}, 64'd0);
    check("rst_out_adel", 64'(out_adel), 64'd0);
    rst = 1'b0;
    boot_cyc = cyc;
  endtask

  // Returns at negedge+1 of the first cycle spent in state s.
  task automatic go_to(input fetch_state_t s, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      #1;
      if (state == s) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: state %0d not reached, expected %0d", name, state, s);
    end
  endtask

  task automatic wait_hs(input int n, input string name);
    int target = hs_count + n;
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #4;
      if (hs_count >= target) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: got %0d deliveries, expected %0d", name, hs_count, target);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d undelivered, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Sequential fetch, zero-wait bus, ID always ready.
    do_reset();
    out_ready = 1'b1;
    #1;
    check("boot_pc_en", 64'(pc_en), 64'd1);
    check("boot_next_pc", 64'(next_pc), 64'hBFC0_0000);
    exp_q.push_back(pack_exp(32'hBFC0_0000, 32'h2408_0001, 1'b0));
    exp_q.push_back(pack_exp(32'hBFC0_0004, 32'h2408_0005, 1'b0));
    exp_q.push_back(pack_exp(32'hBFC0_0008, 32'h2408_0009, 1'b0));
    begin
      int first = hs_cyc.size();
      wait_hs(3, "seq_deliveries");
      for (int i = 0; i < 3; i++)
        if (hs_cyc.size() > first + i)
          check($sformatf("seq_cycle_%0d", i), 64'(hs_cyc[first + i] - boot_cyc), 64'(3 * (i + 1)));
    end
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check_drained("seq_drained");

    // ID stall in HOLD.
    do_reset();
    go_to(ST_HOLD, "stall_reach_hold");
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_out", {out_pc, out_inst}, {32'hBFC0_0000, 32'h2408_0001});
      check("stall_pc_en", 64'(pc_en), 64'd0);
      @(negedge clk);
      #1;
    end
    exp_q.push_back(pack_exp(32'hBFC0_0000, 32'h2408_0001, 1'b0));
    out_ready = 1'b1;
    #1;
    check("release_pc_en", 64'(pc_en), 64'd1);
    check("release_next_pc", 64'(next_pc), 64'hBFC0_0004);
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check_drained("stall_drained");

    // Branch during WAIT with slow data: stale data dropped.
    do_reset();
    out_ready = 1'b1;
    lat = 2;
    exp_q.push_back(pack_exp(32'h8000_1000, 32'h2408_1001, 1'b0));
    go_to(ST_WAIT, "wbr_reach_wait");
    br_valid = 1'b1;
    br_target = 32'h8000_1000;
    #1;
    check("wbr_pc_en", 64'(pc_en), 64'd1);
    check("wbr_next_pc", 64'(next_pc), 64'h8000_1000);
    @(negedge clk);
    #1;
    br_valid = 1'b0;
    #1;
    check("wbr_still_wait", 64'(state), 64'(ST_WAIT));
    @(negedge clk);
    #2;
    check("wbr_data_cycle_wait", 64'(state), 64'(ST_WAIT));
    lat = 0;
    @(negedge clk);
    #2;
    check("wbr_refetch_state", 64'(state), 64'(ST_REQ));
    check("wbr_refetch_req", 64'(inst_req), 64'd1);
    check("wbr_refetch_addr", 64'(inst_addr), 64'h8000_1000);
    check("wbr_no_valid", 64'(out_valid), 64'd0);
    wait_hs(1, "wbr_delivery");
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check_drained("wbr_drained");

    // Exception and branch together in HOLD: exception wins.
    do_reset();
    go_to(ST_HOLD, "hexc_reach_hold");
    exc_valid = 1'b1;
    exc_target = 32'hBFC0_0380;
    br_valid = 1'b1;
    br_target = 32'h8000_2000;
    #1;
    check("hexc_pc_en", 64'(pc_en), 64'd1);
    check("hexc_next_pc", 64'(next_pc), 64'hBFC0_0380);
    @(negedge clk);
    #1;
    exc_valid = 1'b0;
    br_valid = 1'b0;
    #1;
    check("hexc_dropped", 64'(out_valid), 64'd0);
    check("hexc_state", 64'(state), 64'(ST_REQ));
    check("hexc_addr", 64'(inst_addr), 64'hBFC0_0380);
    exp_q.push_back(pack_exp(32'hBFC0_0380, 32'h2408_0381, 1'b0));
    out_ready = 1'b1;
    wait_hs(1, "hexc_delivery");
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check_drained("hexc_drained");

    // Redirect in REQ while the address is accepted.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(pack_exp(32'h8000_2000, 32'h2408_2001, 1'b0));
    go_to(ST_REQ, "racc_reach_req");
    br_valid = 1'b1;
    br_target = 32'h8000_2000;
    #1;
    check("racc_pc_en", 64'(pc_en), 64'd1);
    check("racc_next_pc", 64'(next_pc), 64'h8000_2000);
    @(negedge clk);
    #1;
    br_valid = 1'b0;
    #1;
    check("racc_wait", 64'(state), 64'(ST_WAIT));
    @(negedge clk);
    #2;
    check("racc_refetch_state", 64'(state), 64'(ST_REQ));
    check("racc_refetch_addr", 64'(inst_addr), 64'h8000_2000);
    check("racc_no_valid", 64'(out_valid), 64'd0);
    wait_hs(1, "racc_delivery");
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check_drained("racc_drained");

    // Redirect in REQ while the bus refuses the address.
    do_reset();
    out_ready = 1'b1;
    addr_block = 1'b1;
    exp_q.push_back(pack_exp(32'h8000_3000, 32'h2408_3001, 1'b0));
    go_to(ST_REQ, "rblk_reach_req");
    br_valid = 1'b1;
    br_target = 32'h8000_3000;
    #1;
    check("rblk_next_pc", 64'(next_pc), 64'h8000_3000);
    @(negedge clk);
    #1;
    br_valid = 1'b0;
    #1;
    check("rblk_stay_req", 64'(state), 64'(ST_REQ));
    check("rblk_addr", 64'(inst_addr), 64'h8000_3000);
    addr_block = 1'b0;
    wait_hs(1, "rblk_delivery");
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check_drained("rblk_drained");

    // Branch to a misaligned target.
    do_reset();
    go_to(ST_HOLD, "mis_reach_hold");
    br_valid = 1'b1;
    br_target = 32'h8000_0002;
    @(negedge clk);
    #1;
    br_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_no_req", 64'(inst_req), 64'd0);
    exp_q.push_back(pack_exp(32'h8000_0002, 32'h0, 1'b1));
    @(negedge clk);
    #1;
    check("mis_valid", 64'(out_valid), 64'd1);
    check("mis_adel", 64'(out_adel), 64'd1);
    check("mis_out", {out_pc, out_inst}, {32'h8000_0002, 32'h0});
    check("mis_no_req_hold", 64'(inst_req), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    out_ready = 1'b0;
`else
    check("mis_req", 64'(inst_req), 64'd1);
    check("mis_addr", 64'(inst_addr), 64'h8000_0002);
    exp_q.push_back(pack_exp(32'h8000_0002, 32'h2408_0003, 1'b0));
    out_ready = 1'b1;
    wait_hs(1, "mis_delivery");
    @(negedge clk);
    #1;
    out_ready = 1'b0;
`endif
    check_drained("mis_drained");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
